// File: rtl/breathe_pwm_mc.sv
// Multi-channel PWM engine on a shared period counter.
// Each channel runs a static duty or a triangle-ramped breathing duty.
module breathe_pwm_mc #(
  parameter int PERIOD      = 12000,
  parameter int CW          = 16,
  parameter int CH          = 4,
  parameter int STEP        = 1,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CH-1:0]    mode,
  input  logic [CH*CW-1:0] duty_in,
  input  logic             load,
  output logic [CH-1:0]    pwm_out,
  output logic [CH-1:0]    dir,
  output logic             period_tick
);

  localparam logic [CW-1:0] PER    = CW'(PERIOD);
  localparam logic [CW-1:0] PER_M1 = CW'(PERIOD - 1);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
  localparam logic [CW:0]   PER_X  = (CW+1)'(PERIOD);
  localparam logic [CW:0]   STEP_X = (CW+1)'(STEP);
  localparam logic [CH-1:0] IDLE   =
    (ACTIVE_HIGH == 0) ? {CH{1'b1}} : {CH{1'b0}};

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CH-1:0][CW-1:0]  duty_q, duty_d;
  logic [CH-1:0][CW-1:0]  shadow_q, shadow_d;
  logic [CH-1:0]          dir_q, dir_d;
  logic [CH-1:0]          pwm_q, pwm_d;
  logic                   tick_q, tick_d;

  logic                   boundary;
  logic [CH-1:0][CW-1:0]  sat;
  logic [CH-1:0][CW:0]    up;
  logic [CH-1:0]          raw;

  always_comb begin
    boundary = en && (cnt_q == PER_M1);
    cnt_d    = '0;
    if (en && !boundary) begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = boundary;
  end

  // Saturate incoming duty so a period is never over-driven.
  always_comb begin
    sat = '0;
    for (int k = 0; k < CH; k++) begin
      if (duty_in[k*CW +: CW] > PER) begin
        sat[k] = PER;
      end else begin
        sat[k] = duty_in[k*CW +: CW];
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    duty_d   = duty_q;
    dir_d    = dir_q;
    up       = '0;
    for (int k = 0; k < CH; k++) begin
      up[k] = {1'b0, duty_q[k]} + STEP_X;
      if (load) begin
        shadow_d[k] = sat[k];
      end
      if (boundary) begin
        unique case (1'b1)
          !mode[k]: begin
            duty_d[k] = load ? sat[k] : shadow_q[k];
          end
          mode[k] && dir_q[k]: begin
            if (up[k] >= PER_X) begin
              duty_d[k] = PER;
              dir_d[k]  = 1'b0;
            end else begin
              duty_d[k] = up[k][CW-1:0];
            end
          end
          default: begin
            if ({1'b0, duty_q[k]} <= STEP_X) begin
              duty_d[k] = '0;
              dir_d[k]  = 1'b1;
            end else begin
              duty_d[k] = duty_q[k] - STEP_C;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int k = 0; k < CH; k++) begin
      raw[k] = (cnt_q < duty_q[k]);
    end
    pwm_d = en ? (raw ^ IDLE) : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      duty_q   <= '0;
      shadow_q <= '0;
      dir_q    <= '1;
      pwm_q    <= IDLE;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      dir_q    <= dir_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign dir         = dir_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_breathe_pwm_mc.sv
// Scoreboard bench for breathe_pwm_mc: random and directed stimulus
// against a per-cycle reference model, active-high and active-low builds.
module tb_breathe_pwm_mc;

  localparam int P  = 10;
  localparam int CW = 8;
  localparam int CH = 4;
  localparam int ST = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [CH-1:0]    mode = '0;
  logic [CH*CW-1:0] duty_in = '0;

  logic [CH-1:0] pwm_h, dir_h, pwm_l, dir_l;
  logic          tick_h, tick_l;

  breathe_pwm_mc #(
    .PERIOD(P), .CW(CW), .CH(CH), .STEP(ST), .ACTIVE_HIGH(1)
  ) u_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .duty_in(duty_in), .load(load),
    .pwm_out(pwm_h), .dir(dir_h), .period_tick(tick_h)
  );

  breathe_pwm_mc #(
    .PERIOD(P), .CW(CW), .CH(CH), .STEP(ST), .ACTIVE_HIGH(0)
  ) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .duty_in(duty_in), .load(load),
    .pwm_out(pwm_l), .dir(dir_l), .period_tick(tick_l)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic [CH-1:0] dir;
    logic          tick;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_cnt;
  int   m_duty[CH];
  int   m_sh[CH];
  bit   m_dir[CH];

  task automatic model_reset();
    m_cnt = 0;
    for (int k = 0; k < CH; k++) begin
      m_duty[k] = 0;
      m_sh[k]   = 0;
      m_dir[k]  = 1'b1;
    end
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    exp_t x;
    bit   b;
    int   s;
    x = '0;
    if (!rst_n) begin
      model_reset();
      x.dir = '1;
    end else begin
      b = en && (m_cnt == P - 1);
      x.tick = b;
      for (int k = 0; k < CH; k++) begin
        x.pwm[k] = en && (m_cnt < m_duty[k]);
        s = int'(duty_in[k*CW +: CW]);
        if (s > P) s = P;
        if (b) begin
          if (!mode[k]) begin
            m_duty[k] = load ? s : m_sh[k];
          end else if (m_dir[k]) begin
            if (m_duty[k] + ST >= P) begin
              m_duty[k] = P;
              m_dir[k]  = 1'b0;
            end else begin
              m_duty[k] = m_duty[k] + ST;
            end
          end else begin
            if (m_duty[k] <= ST) begin
              m_duty[k] = 0;
              m_dir[k]  = 1'b1;
            end else begin
              m_duty[k] = m_duty[k] - ST;
            end
          end
        end
        if (load) m_sh[k] = s;
        x.dir[k] = m_dir[k];
      end
      m_cnt = !en ? 0 : (b ? 0 : m_cnt + 1);
    end
    q.push_back(x);
  endtask

  task automatic cyc(input logic r, input logic e, input logic [CH-1:0] m,
                     input logic [CH*CW-1:0] d, input logic l);
    @(negedge clk);
    rst_n   = r;
    en      = e;
    mode    = m;
    duty_in = d;
    load    = l;
    model_step();
  endtask

  function automatic logic [CH*CW-1:0] rnd_duty();
    logic [CH*CW-1:0] d;
    d = '0;
    for (int k = 0; k < CH; k++) begin
      d[k*CW +: CW] = CW'($urandom_range(0, 13));
    end
    return d;
  endfunction

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_cmp++;
        if ({pwm_h, dir_h, tick_h} !== x) begin
          n_bad++;
          $display("FAIL sb_hi t=%0t got pwm=%b dir=%b tick=%b want pwm=%b dir=%b tick=%b",
                   $time, pwm_h, dir_h, tick_h, x.pwm, x.dir, x.tick);
        end
        n_cmp++;
        if ({pwm_l, dir_l, tick_l} !== {~x.pwm, x.dir, x.tick}) begin
          n_bad++;
          $display("FAIL sb_lo t=%0t got pwm=%b dir=%b tick=%b want pwm=%b dir=%b tick=%b",
                   $time, pwm_l, dir_l, tick_l, ~x.pwm, x.dir, x.tick);
        end
      end
    end
  end

  initial begin : stim
    logic [CH*CW-1:0] d;
    logic [CH-1:0]    m;
    model_reset();

    // Reset held with en high and inputs toggling.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, CH'($urandom), rnd_duty(), 1'($urandom));
    end

    // Breathing from reset on every channel.
    for (int i = 0; i < 10 * P + 3; i++) begin
      cyc(1'b1, 1'b1, '1, '0, 1'b0);
    end

    // Static with load, including a saturating value.
    d = '0;
    d[0*CW +: CW] = 8'd4;
    d[1*CW +: CW] = 8'd0;
    d[2*CW +: CW] = 8'd12;
    d[3*CW +: CW] = 8'd7;
    cyc(1'b1, 1'b1, '0, d, 1'b1);
    for (int i = 0; i < 4 * P; i++) begin
      cyc(1'b1, 1'b1, '0, '0, 1'b0);
    end

    // Shadow = 2, then load 7 on the boundary edge itself.
    d = '0;
    for (int k = 0; k < CH; k++) d[k*CW +: CW] = 8'd2;
    cyc(1'b1, 1'b1, '0, d, 1'b1);
    while (m_cnt != P - 1) cyc(1'b1, 1'b1, '0, '0, 1'b0);
    for (int k = 0; k < CH; k++) d[k*CW +: CW] = 8'd7;
    cyc(1'b1, 1'b1, '0, d, 1'b1);
    for (int i = 0; i < 2 * P; i++) begin
      cyc(1'b1, 1'b1, '0, '0, 1'b0);
    end

    // Drop enable mid-period, then resume with retained duty.
    while (m_cnt != 5) cyc(1'b1, 1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3 * P; i++) cyc(1'b1, 1'b1, '0, '0, 1'b0);

    // Randomised traffic.
    m = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) m[$urandom_range(0, CH-1)] ^= 1'b1;
      cyc(1'b1, ($urandom_range(0, 19) != 0), m, rnd_duty(),
          ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pwm_h, dir_h, tick_h} !== {{CH{1'b0}}, {CH{1'b1}}, 1'b0}) begin
      n_bad++;
      $display("FAIL async_rst_hi got pwm=%b dir=%b tick=%b want pwm=0 dir=1 tick=0",
               pwm_h, dir_h, tick_h);
    end
    n_cmp++;
    if ({pwm_l, dir_l, tick_l} !== {{CH{1'b1}}, {CH{1'b1}}, 1'b0}) begin
      n_bad++;
      $display("FAIL async_rst_lo got pwm=%b dir=%b tick=%b want pwm=1 dir=1 tick=0",
               pwm_l, dir_l, tick_l);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '1, rnd_duty(), 1'b1);
    for (int i = 0; i < 4 * P; i++) cyc(1'b1, 1'b1, 4'b0101, rnd_duty(), 1'b0);

    @(posedge clk);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
